// File: rtl/multibank_read_return.sv
// Read-return path of the multi-bank memory: decodes a top-level read into a bank
// enable, tracks each read's bank through a latency-matched pipeline, and steers data back.
`timescale 1ns/1ps

module multibank_read_return #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [3:0]            o_bank_rd_en,
    output logic [ADDR_WIDTH-3:0] o_bank_addr,
    input  logic [DATA_WIDTH-1:0] i_bank_rdata0,
    input  logic [DATA_WIDTH-1:0] i_bank_rdata1,
    input  logic [DATA_WIDTH-1:0] i_bank_rdata2,
    input  logic [DATA_WIDTH-1:0] i_bank_rdata3,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic [1:0]            o_rd_bank,
    output logic                  o_busy
);

    logic [1:0]            req_sel;
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] vld_d;
    logic [1:0]            sel_q [RD_LATENCY];
    logic [1:0]            sel_d [RD_LATENCY];
    logic                  ret_vld;
    logic [1:0]            ret_sel;
    logic [DATA_WIDTH-1:0] ret_data;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [1:0]            rd_bank_q;
    logic                  rd_valid_q;

    // Request decode
    assign req_sel     = i_address[ADDR_WIDTH-1 -: 2];
    assign o_bank_addr = i_address[ADDR_WIDTH-3:0];

    always_comb begin
        o_bank_rd_en          = '0;
        o_bank_rd_en[req_sel] = i_rd_en;
    end

    // Tracking pipeline: stage 0 captures the request, later stages shift unconditionally
    always_comb begin
        vld_d[0] = i_rd_en;
        sel_d[0] = req_sel;
        for (int k = 1; k < RD_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            sel_d[k] = sel_q[k-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                sel_q[k] <= 2'd0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < RD_LATENCY; k++) begin
                sel_q[k] <= sel_d[k];
            end
        end
    end

    assign ret_vld = vld_q[RD_LATENCY-1];
    assign ret_sel = sel_q[RD_LATENCY-1];

    // Data steering: a true mux so unknowns on unselected banks never reach the output
    always_comb begin
        ret_data = i_bank_rdata0;
        case (ret_sel)
            2'd0:    ret_data = i_bank_rdata0;
            2'd1:    ret_data = i_bank_rdata1;
            2'd2:    ret_data = i_bank_rdata2;
            default: ret_data = i_bank_rdata3;
        endcase
    end

    // Return register: data and bank hold between returns
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data_q  <= '0;
            rd_bank_q  <= 2'd0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= ret_vld;
            if (ret_vld) begin
                rd_data_q <= ret_data;
                rd_bank_q <= ret_sel;
            end
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_bank  = rd_bank_q;
    assign o_rd_valid = rd_valid_q;
    assign o_busy     = |vld_q;

endmodule

// File: tb/tb_multibank_read_return.sv
// Directed bench: three instances (RD_LATENCY 1, 3, 2) driven by a simple bank model.
`timescale 1ns/1ps

module tb_multibank_read_return;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       xmode;
    logic       rd_en     [3];
    logic [3:0] addr_in   [3];
    logic [3:0] bank_en   [3];
    logic [1:0] bank_addr [3];
    logic [7:0] brd       [3][4];
    logic [7:0] rd_data   [3];
    logic       rd_valid  [3];
    logic [1:0] rd_bank   [3];
    logic       busy      [3];
    logic [7:0] mem       [3][4][4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        logic [3:0] en_h [4];
        logic [1:0] ad_h [4];

        // Bank model: a bank enabled in cycle T presents mem contents in cycle T+LAT
        always_ff @(posedge clk) begin
            en_h[0] <= bank_en[g];
            ad_h[0] <= bank_addr[g];
            for (int k = 1; k < 4; k++) begin
                en_h[k] <= en_h[k-1];
                ad_h[k] <= ad_h[k-1];
            end
        end

        for (genvar n = 0; n < 4; n++) begin : g_bank
            assign brd[g][n] = en_h[LAT-1][n] ? mem[g][n][ad_h[LAT-1]]
                                              : (xmode ? 8'hxx : (8'hE0 | 8'(n)));
        end

        multibank_read_return #(
            .DATA_WIDTH(8),
            .ADDR_WIDTH(4),
            .RD_LATENCY(LAT)
        ) u_dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_rd_en      (rd_en[g]),
            .i_address    (addr_in[g]),
            .o_bank_rd_en (bank_en[g]),
            .o_bank_addr  (bank_addr[g]),
            .i_bank_rdata0(brd[g][0]),
            .i_bank_rdata1(brd[g][1]),
            .i_bank_rdata2(brd[g][2]),
            .i_bank_rdata3(brd[g][3]),
            .o_rd_data    (rd_data[g]),
            .o_rd_valid   (rd_valid[g]),
            .o_rd_bank    (rd_bank[g]),
            .o_busy       (busy[g])
        );
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int g, input logic en, input logic [3:0] a);
        rd_en[g]   = en;
        addr_in[g] = a;
    endtask

    task automatic chk_idle_out(input string tag, input int g);
        chk_val({tag, "_data"},  32'(rd_data[g]),  32'h0);
        chk_val({tag, "_valid"}, 32'(rd_valid[g]), 32'h0);
        chk_val({tag, "_bank"},  32'(rd_bank[g]),  32'h0);
        chk_val({tag, "_busy"},  32'(busy[g]),     32'h0);
    endtask

    initial begin
        logic       ev;
        logic [7:0] ed;
        logic [1:0] eb;
        logic       ebusy;

        for (int g = 0; g < 3; g++)
            for (int n = 0; n < 4; n++)
                for (int a = 0; a < 4; a++)
                    mem[g][n][a] = 8'h00;
        xmode = 1'b0;

        // Reset with garbage on the inputs, checked before any clock edge
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) drive(g, 1'b1, 4'hB);
        #2;
        for (int g = 0; g < 3; g++) chk_idle_out("rst_init", g);
        chk_val("rst_init_bank_en", 32'(bank_en[0]), 32'h4);
        for (int g = 0; g < 3; g++) drive(g, 1'b0, 4'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single read, latency 1
        mem[0][2][1] = 8'hA5;
        drive(0, 1'b1, 4'b1001);
        #1;
        chk_val("t1_bank_en",   32'(bank_en[0]),   32'h4);
        chk_val("t1_bank_addr", 32'(bank_addr[0]), 32'h1);
        chk_val("t1_busy0",     32'(busy[0]),      32'h0);
        step();
        drive(0, 1'b0, 4'b1001);
        #1;
        chk_val("t1_bank_en_off", 32'(bank_en[0]),  32'h0);
        chk_val("t1_busy1",       32'(busy[0]),     32'h1);
        chk_val("t1_valid1",      32'(rd_valid[0]), 32'h0);
        step();
        chk_val("t1_valid2", 32'(rd_valid[0]), 32'h1);
        chk_val("t1_data2",  32'(rd_data[0]),  32'hA5);
        chk_val("t1_bank2",  32'(rd_bank[0]),  32'h2);
        chk_val("t1_busy2",  32'(busy[0]),     32'h0);
        step();
        chk_val("t1_valid3", 32'(rd_valid[0]), 32'h0);
        chk_val("t1_hold3",  32'(rd_data[0]),  32'hA5);

        // Asynchronous reset with a read in flight and garbage on the inputs
        drive(0, 1'b1, 4'b0110);
        step();
        drive(0, 1'b1, 4'hF);
        chk_val("rst_async_busy_pre", 32'(busy[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_idle_out("rst_async", 0);
        chk_val("rst_async_bank_en", 32'(bank_en[0]), 32'h8);
        step();
        drive(0, 1'b0, 4'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk_val("rst_async_novalid", 32'(rd_valid[0]), 32'h0);
            step();
        end

        // Back-to-back to banks 0..3, latency 3
        for (int n = 0; n < 4; n++)
            for (int a = 0; a < 4; a++)
                mem[1][n][a] = 8'h10 + 8'(n);
        for (int c = 0; c < 10; c++) begin
            drive(1, c < 4, {2'(c), 2'(3 - c)});
            #1;
            ev    = (c >= 4) && (c <= 7);
            ebusy = (c >= 1) && (c <= 6);
            chk_val("t3_busy",  32'(busy[1]),     32'(ebusy));
            chk_val("t3_valid", 32'(rd_valid[1]), 32'(ev));
            if (ev) begin
                chk_val("t3_data", 32'(rd_data[1]), 32'h10 + 32'(c - 4));
                chk_val("t3_bank", 32'(rd_bank[1]), 32'(c - 4));
            end
            step();
        end

        // Same-bank streaming with unknowns on the other banks
        for (int a = 0; a < 4; a++) mem[1][3][a] = 8'(a);
        xmode = 1'b1;
        for (int c = 0; c < 13; c++) begin
            drive(1, c < 8, {2'b11, 2'(c)});
            #1;
            ev = (c >= 4) && (c <= 11);
            chk_val("t4_valid", 32'(rd_valid[1]), 32'(ev));
            if (ev) begin
                chk_val("t4_data", 32'(rd_data[1]), 32'((c - 4) % 4));
                chk_val("t4_bank", 32'(rd_bank[1]), 32'h3);
                chk_val("t4_nox",  32'($isunknown(rd_data[1])), 32'h0);
            end
            step();
        end
        xmode = 1'b0;

        // Reset mid-flight, latency 2
        drive(2, 1'b1, 4'b0101);
        step();
        drive(2, 1'b1, 4'b1100);
        step();
        drive(2, 1'b0, 4'h0);
        chk_val("t5_busy_pre", 32'(busy[2]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_val("t5_busy_rst", 32'(busy[2]), 32'h0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk_val("t5_novalid", 32'(rd_valid[2]), 32'h0);
            chk_val("t5_busy",    32'(busy[2]),     32'h0);
            step();
        end

        // Gapped traffic, latency 2: reads in cycles 0, 2, 5
        mem[2][1][0] = 8'h5A;
        mem[2][2][3] = 8'hC3;
        mem[2][0][2] = 8'h7E;
        for (int c = 0; c < 11; c++) begin
            case (c)
                0:       drive(2, 1'b1, 4'b0100);
                2:       drive(2, 1'b1, 4'b1011);
                5:       drive(2, 1'b1, 4'b0010);
                default: drive(2, 1'b0, 4'h0);
            endcase
            #1;
            ev    = (c == 3) || (c == 5) || (c == 8);
            ebusy = (c == 1) || (c == 2) || (c == 3) || (c == 4) || (c == 6) || (c == 7);
            ed    = (c < 3) ? 8'h00 : (c < 5) ? 8'h5A : (c < 8) ? 8'hC3 : 8'h7E;
            eb    = (c < 3) ? 2'd0  : (c < 5) ? 2'd1  : (c < 8) ? 2'd2  : 2'd0;
            chk_val("t6_valid", 32'(rd_valid[2]), 32'(ev));
            chk_val("t6_data",  32'(rd_data[2]),  32'(ed));
            chk_val("t6_bank",  32'(rd_bank[2]),  32'(eb));
            chk_val("t6_busy",  32'(busy[2]),     32'(ebusy));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
